// File: rtl/ps2_kbd_host_if_if.sv
// Bundle between the PS/2 receive FIFO, the 60h/64h I/O decoder and the host interface.
// Ports: receiver FIFO head/empty/pop/error flags, bus cs/addr/rd/dout, irq1.
interface ps2_kbd_host_if_if;
    logic [7:0] kb_fifo_top;
    logic       kb_rx_empty;
    logic       kb_pop;
    logic       kb_frame_error;
    logic       kb_parity_error;
    logic       kb_rx_overflow;
    logic       cs;
    logic       addr;
    logic       rd;
    logic [7:0] dout;
    logic       irq1;

    modport master (
        output kb_fifo_top, kb_rx_empty,
        output kb_frame_error, kb_parity_error, kb_rx_overflow,
        output cs, addr, rd,
        input  kb_pop, dout, irq1
    );

    modport slave (
        input  kb_fifo_top, kb_rx_empty,
        input  kb_frame_error, kb_parity_error, kb_rx_overflow,
        input  cs, addr, rd,
        output kb_pop, dout, irq1
    );
endinterface

// File: rtl/ps2_kbd_host_if.sv
// 8042-style keyboard host: pops PS/2 set-2 bytes, optional set-1 translation
// (macro KBD_XLAT_EN), data port 60h / status port 64h, IRQ1 = OBF.
// Ports: busclk, rst (sync, active-high), bus (slave modport of ps2_kbd_host_if_if).
module ps2_kbd_host_if #(
    parameter bit STATUS_SYS = 1'b1
) (
    input  logic                busclk,
    input  logic                rst,
    ps2_kbd_host_if_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE, ALIGN, TAKE, HOLD, RECOVER
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] out_data_q, out_data_d;
    logic       obf_q, obf_d;
    logic [7:0] pend_q, pend_d;
    logic       pop_c;
    logic       rd_data;

    assign rd_data = bus.cs & bus.rd & ~bus.addr;

`ifdef KBD_XLAT_EN
    logic brk_q, brk_d;
    // Prefix bytes keep a pending break flag alive across the E0/E1 byte.
    logic pfx_q, pfx_d;
    logic is_pfx;
    logic [7:0] rom;
    logic [7:0] xlat;

    assign is_pfx = (bus.kb_fifo_top == 8'hE0) | (bus.kb_fifo_top == 8'hE1);
    assign xlat   = is_pfx ? bus.kb_fifo_top : (rom | {brk_q, 7'b0});

    always_comb begin
        rom = 8'h00;
        case (bus.kb_fifo_top)
            8'h01: rom = 8'h43;  8'h03: rom = 8'h3F;
            8'h04: rom = 8'h3D;  8'h05: rom = 8'h3B;
            8'h06: rom = 8'h3C;  8'h07: rom = 8'h58;
            8'h09: rom = 8'h44;  8'h0A: rom = 8'h42;
            8'h0B: rom = 8'h40;  8'h0C: rom = 8'h3E;
            8'h0D: rom = 8'h0F;  8'h0E: rom = 8'h29;
            8'h11: rom = 8'h38;  8'h12: rom = 8'h2A;
            8'h14: rom = 8'h1D;  8'h15: rom = 8'h10;
            8'h16: rom = 8'h02;  8'h1A: rom = 8'h2C;
            8'h1B: rom = 8'h1F;  8'h1C: rom = 8'h1E;
            8'h1D: rom = 8'h11;  8'h1E: rom = 8'h03;
            8'h21: rom = 8'h2E;  8'h22: rom = 8'h2D;
            8'h23: rom = 8'h20;  8'h24: rom = 8'h12;
            8'h25: rom = 8'h05;  8'h26: rom = 8'h04;
            8'h29: rom = 8'h39;  8'h2A: rom = 8'h2F;
            8'h2B: rom = 8'h21;  8'h2C: rom = 8'h14;
            8'h2D: rom = 8'h13;  8'h2E: rom = 8'h06;
            8'h31: rom = 8'h31;  8'h32: rom = 8'h30;
            8'h33: rom = 8'h23;  8'h34: rom = 8'h22;
            8'h35: rom = 8'h15;  8'h36: rom = 8'h07;
            8'h3A: rom = 8'h32;  8'h3B: rom = 8'h24;
            8'h3C: rom = 8'h16;  8'h3D: rom = 8'h08;
            8'h3E: rom = 8'h09;  8'h41: rom = 8'h33;
            8'h42: rom = 8'h25;  8'h43: rom = 8'h17;
            8'h44: rom = 8'h18;  8'h45: rom = 8'h0B;
            8'h46: rom = 8'h0A;  8'h49: rom = 8'h34;
            8'h4A: rom = 8'h35;  8'h4B: rom = 8'h26;
            8'h4C: rom = 8'h27;  8'h4D: rom = 8'h19;
            8'h4E: rom = 8'h0C;  8'h52: rom = 8'h28;
            8'h54: rom = 8'h1A;  8'h55: rom = 8'h0D;
            8'h58: rom = 8'h3A;  8'h59: rom = 8'h36;
            8'h5A: rom = 8'h1C;  8'h5B: rom = 8'h1B;
            8'h5D: rom = 8'h2B;  8'h61: rom = 8'h56;
            8'h66: rom = 8'h0E;  8'h69: rom = 8'h4F;
            8'h6B: rom = 8'h4B;  8'h6C: rom = 8'h47;
            8'h70: rom = 8'h52;  8'h71: rom = 8'h53;
            8'h72: rom = 8'h50;  8'h73: rom = 8'h4C;
            8'h74: rom = 8'h4D;  8'h75: rom = 8'h48;
            8'h76: rom = 8'h01;  8'h77: rom = 8'h45;
            8'h78: rom = 8'h57;  8'h79: rom = 8'h4E;
            8'h7A: rom = 8'h51;  8'h7B: rom = 8'h4A;
            8'h7C: rom = 8'h37;  8'h7D: rom = 8'h49;
            8'h7E: rom = 8'h46;  8'h83: rom = 8'h41;
            default: rom = 8'h00;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        obf_d      = obf_q;
        pend_d     = pend_q;
        pop_c      = 1'b0;
`ifdef KBD_XLAT_EN
        brk_d      = brk_q;
        pfx_d      = pfx_q;
`endif
        // A data read only clears a full buffer; HOLD never loads while
        // obf_q is set, so the two updates below cannot collide.
        if (rd_data && obf_q)
            obf_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.kb_rx_empty)
                    state_d = ALIGN;
            end
            ALIGN: state_d = TAKE;
            TAKE: begin
                pop_c = 1'b1;
`ifdef KBD_XLAT_EN
                if (bus.kb_fifo_top == 8'hF0) begin
                    brk_d   = 1'b1;
                    state_d = RECOVER;
                end else begin
                    pend_d  = xlat;
                    pfx_d   = is_pfx;
                    state_d = HOLD;
                end
`else
                pend_d  = bus.kb_fifo_top;
                state_d = HOLD;
`endif
            end
            HOLD: begin
                if (!obf_q) begin
                    out_data_d = pend_q;
                    obf_d      = 1'b1;
`ifdef KBD_XLAT_EN
                    if (!pfx_q)
                        brk_d = 1'b0;
`endif
                    state_d    = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge busclk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= 8'h00;
            obf_q      <= 1'b0;
            pend_q     <= 8'h00;
`ifdef KBD_XLAT_EN
            brk_q      <= 1'b0;
            pfx_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            obf_q      <= obf_d;
            pend_q     <= pend_d;
`ifdef KBD_XLAT_EN
            brk_q      <= brk_d;
            pfx_q      <= pfx_d;
`endif
        end
    end

    assign bus.kb_pop = pop_c;
    assign bus.irq1   = obf_q;
    assign bus.dout   = bus.addr
        ? {bus.kb_parity_error, bus.kb_frame_error, bus.kb_rx_overflow,
           1'b1, 1'b0, STATUS_SYS, 1'b0, obf_q}
        : out_data_q;

endmodule

// File: tb/tb_ps2_kbd_host_if.sv
// Bench for ps2_kbd_host_if: receiver FIFO model, queue-based scoreboard,
// stream-level reference of the set-2 to set-1 / break folding rules.
module tb_ps2_kbd_host_if;

    logic busclk = 1'b0;
    logic rst    = 1'b1;

    ps2_kbd_host_if_if kbif ();

    ps2_kbd_host_if #(.STATUS_SYS(1'b1)) dut (
        .busclk (busclk),
        .rst    (rst),
        .bus    (kbif)
    );

    always #5 busclk = ~busclk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [7:0] fifo [$];
    logic [7:0] exp_q [$];
    logic [7:0] last_out = 8'h00;
    logic [7:0] head_q = 8'h00;
    logic [7:0] xl [256];
    bit         mbrk = 1'b0;

    logic [15:0] pairs [$] = '{
        16'h0143, 16'h033F, 16'h043D, 16'h053B, 16'h063C, 16'h0758,
        16'h0944, 16'h0A42, 16'h0B40, 16'h0C3E, 16'h0D0F, 16'h0E29,
        16'h1138, 16'h122A, 16'h141D, 16'h1510, 16'h1602, 16'h1A2C,
        16'h1B1F, 16'h1C1E, 16'h1D11, 16'h1E03, 16'h212E, 16'h222D,
        16'h2320, 16'h2412, 16'h2505, 16'h2604, 16'h2939, 16'h2A2F,
        16'h2B21, 16'h2C14, 16'h2D13, 16'h2E06, 16'h3131, 16'h3230,
        16'h3323, 16'h3422, 16'h3515, 16'h3607, 16'h3A32, 16'h3B24,
        16'h3C16, 16'h3D08, 16'h3E09, 16'h4133, 16'h4225, 16'h4317,
        16'h4418, 16'h450B, 16'h460A, 16'h4934, 16'h4A35, 16'h4B26,
        16'h4C27, 16'h4D19, 16'h4E0C, 16'h5228, 16'h541A, 16'h550D,
        16'h583A, 16'h5936, 16'h5A1C, 16'h5B1B, 16'h5D2B, 16'h6156,
        16'h660E, 16'h694F, 16'h6B4B, 16'h6C47, 16'h7052, 16'h7153,
        16'h7250, 16'h734C, 16'h744D, 16'h7548, 16'h7601, 16'h7745,
        16'h7857, 16'h794E, 16'h7A51, 16'h7B4A, 16'h7C37, 16'h7D49,
        16'h7E46, 16'h8341
    };

    // Receiver model: empty follows the queue, the head byte lags one cycle.
    always @(posedge busclk) begin
        if (kbif.kb_pop) begin
            pops <= pops + 1;
            if (fifo.size() != 0)
                void'(fifo.pop_front());
        end
        kbif.kb_rx_empty <= (fifo.size() == 0);
        head_q           <= (fifo.size() != 0) ? fifo[0] : 8'h00;
        kbif.kb_fifo_top <= head_q;
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: every data-port read is compared against the scoreboard.
    always @(negedge busclk) begin
        if (!rst && kbif.cs && kbif.rd && !kbif.addr) begin
            if (kbif.irq1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %02h expected none",
                             kbif.dout);
                end else begin
                    last_out = exp_q.pop_front();
                    chk("data", kbif.dout, last_out);
                end
            end else begin
                chk("stale_data", kbif.dout, last_out);
            end
        end
    end

    task automatic tick();
        @(posedge busclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
`ifdef KBD_XLAT_EN
        if (b == 8'hF0) begin
            mbrk = 1'b1;
        end else if (b == 8'hE0 || b == 8'hE1) begin
            exp_q.push_back(b);
        end else begin
            exp_q.push_back(xl[b] | (mbrk ? 8'h80 : 8'h00));
            mbrk = 1'b0;
        end
`else
        exp_q.push_back(b);
`endif
    endtask

    task automatic read_data();
        kbif.cs   = 1'b1;
        kbif.addr = 1'b0;
        kbif.rd   = 1'b1;
        @(negedge busclk);
        tick();
        kbif.cs = 1'b0;
        kbif.rd = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        kbif.cs   = 1'b1;
        kbif.addr = 1'b1;
        kbif.rd   = 1'b1;
        @(negedge busclk);
        v = kbif.dout;
        tick();
        kbif.cs   = 1'b0;
        kbif.rd   = 1'b0;
        kbif.addr = 1'b0;
    endtask

    task automatic wait_irq(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (kbif.irq1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL irq_timeout: got irq1=0 expected 1 within %0d", n);
        end
    endtask

    task automatic drain();
        bit ok;
        while (exp_q.size() != 0) begin
            wait_irq(100, ok);
            if (!ok) begin
                exp_q.delete();
                break;
            end
            read_data();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] b;
        int         base;
        bit         ok;

        foreach (xl[i]) xl[i] = 8'h00;
        foreach (pairs[i]) xl[pairs[i][15:8]] = pairs[i][7:0];

        kbif.cs = 0; kbif.addr = 0; kbif.rd = 0;
        kbif.kb_frame_error = 0;
        kbif.kb_parity_error = 0;
        kbif.kb_rx_overflow = 0;
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_irq1", {7'b0, kbif.irq1}, 8'h00);
        chk("rst_dout", kbif.dout, 8'h00);
        read_status(st);
        chk("rst_status", st, 8'h14);
        read_data();
        idle(20);
        chk("rst_no_pop", pops[7:0], 8'h00);
        chk("rst_pop_low", {7'b0, kbif.kb_pop}, 8'h00);

        // Single make code
        push_byte(8'h1C);
        wait_irq(30, ok);
        chk("make_pops", pops[7:0], 8'h01);
        read_status(st);
        chk("make_obf", st, 8'h15);
        drain();
        chk("make_irq_low", {7'b0, kbif.irq1}, 8'h00);
        read_status(st);
        chk("make_obf_clr", st, 8'h14);

        // Break and extended sequences
        push_byte(8'hF0); push_byte(8'h1C);
        push_byte(8'hE0); push_byte(8'h75);
        drain();
        idle(20);
        chk("brk_fifo_empty", fifo.size() == 0 ? 8'h00 : 8'h01, 8'h00);

        // Backpressure: buffer + one pending only
        base = pops;
        push_byte(8'h76); push_byte(8'h5A); push_byte(8'h29);
        push_byte(8'h1C); push_byte(8'h76);
        idle(200);
        chk("bp_pops", 8'(pops - base), 8'h02);
        drain();

        // Read colliding with a pending load
        push_byte(8'h76); push_byte(8'h5A);
        idle(200);
        read_data();
        chk("coll_obf_low", {7'b0, kbif.irq1}, 8'h00);
        tick();
        chk("coll_reload", {7'b0, kbif.irq1}, 8'h01);
        drain();

        // Status error bits
        kbif.kb_parity_error = 1'b1;
        read_status(st);
        chk("status_parity", st, 8'h94);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 7));
            kbif.kb_parity_error = b[2];
            kbif.kb_frame_error  = b[1];
            kbif.kb_rx_overflow  = b[0];
            read_status(st);
            chk("status_err", st, {b[2:0], 5'b10100});
        end
        kbif.kb_parity_error = 0;
        kbif.kb_frame_error = 0;
        kbif.kb_rx_overflow = 0;

        // Reset discards the buffered and pending bytes
        push_byte(8'h29); push_byte(8'h75);
        idle(200);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        mbrk = 1'b0;
        last_out = 8'h00;
        chk("rst2_irq1", {7'b0, kbif.irq1}, 8'h00);
        idle(20);
        read_status(st);
        chk("rst2_status", st, 8'h14);
        read_data();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3 && fifo.size() < 12) begin
                if ($urandom_range(0, 3) == 0) begin
                    b = ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hE0;
                end else begin
                    b = 8'($urandom_range(0, 255));
                end
                push_byte(b);
            end else if (r < 6 && kbif.irq1) begin
                read_data();
            end else if (r == 6) begin
                read_data();
            end else begin
                tick();
            end
        end
        drain();
        idle(30);
        chk("end_irq_low", {7'b0, kbif.irq1}, 8'h00);
        chk("end_fifo_empty", fifo.size() == 0 ? 8'h00 : 8'h01, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
